// File: rtl/vrased_pkg.sv
// ============================================================================
// vrased_pkg : shared types and constants for the VRASED log drain path.
// Revision   : 1.0
// ============================================================================
`default_nettype none

package vrased_pkg;

   localparam int LOG_ENTRY_W     = 38;
   localparam int LOG_VALID_BIT   = 37;
   localparam int WORDS_PER_ENTRY = 3;
   localparam int OUT_W           = 16;

   // Scan FSM; the per-word W0..W2 phase lives in the serializer.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RD    = 3'd1,
      ST_CAP   = 3'd2,
      ST_WORDS = 3'd3,
      ST_CLR   = 3'd4,
      ST_FIN   = 3'd5
   } drain_state_e;

   typedef enum logic [1:0] {
      WD_IDLE = 2'd0,
      WD_W0   = 2'd1,
      WD_W1   = 2'd2,
      WD_W2   = 2'd3
   } word_state_e;

endpackage

`default_nettype wire

// File: rtl/vrased_log_serializer.sv
// ============================================================================
// vrased_log_serializer : holds one 38-bit log entry and emits it as three
//                         16-bit words on a valid/ready stream.
// Revision              : 1.0
// ============================================================================
`default_nettype none

module vrased_log_serializer
   import vrased_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   load_i,
   input  logic [LOG_ENTRY_W-1:0] data_i,
   input  logic                   out_ready_i,
   output logic [OUT_W-1:0]       out_data_o,
   output logic                   out_valid_o,
   output logic                   out_first_o,
   output logic                   last_o
);

   word_state_e            word_q, word_d;
   logic [LOG_ENTRY_W-1:0] hold_q, hold_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         word_q <= WD_IDLE;
         hold_q <= '0;
      end else begin
         word_q <= word_d;
         hold_q <= hold_d;
      end
   end

   // Outputs decode only registered state, so the word is stable while stalled.
   always_comb begin
      word_d      = word_q;
      hold_d      = hold_q;
      out_data_o  = '0;
      out_valid_o = 1'b0;
      out_first_o = 1'b0;
      last_o      = 1'b0;
      case (word_q)
         WD_IDLE: begin
            if (load_i) begin
               hold_d = data_i;
               word_d = WD_W0;
            end
         end
         WD_W0: begin
            out_valid_o = 1'b1;
            out_first_o = 1'b1;
            out_data_o  = hold_q[15:0];
            if (out_ready_i) word_d = WD_W1;
         end
         WD_W1: begin
            out_valid_o = 1'b1;
            out_data_o  = hold_q[31:16];
            if (out_ready_i) word_d = WD_W2;
         end
         WD_W2: begin
            out_valid_o = 1'b1;
            out_data_o  = {10'b0, hold_q[37:32]};
            if (out_ready_i) begin
               word_d = WD_IDLE;
               last_o = 1'b1;
            end
         end
         default: word_d = WD_IDLE;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/vrased_log_drain.sv
// ============================================================================
// vrased_log_drain : scans the VRASED violation-log RAM, streams valid entries
//                    and optionally clears the log after a complete scan.
// Revision         : 1.0
// ============================================================================
`default_nettype none

module vrased_log_drain
   import vrased_pkg::*;
#(
   parameter int ADDR_WIDTH  = 8,
   parameter bit CLEAR_AFTER = 1'b1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   output logic                   re,
   output logic [15:0]            rd_addr,
   input  logic [LOG_ENTRY_W-1:0] rd_data,
   output logic                   clr_ram,
   output logic [OUT_W-1:0]       out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_first,
   output logic [ADDR_WIDTH:0]    entry_cnt
);

   localparam logic [ADDR_WIDTH:0] LAST_ADDR = {1'b0, {ADDR_WIDTH{1'b1}}};

   drain_state_e          state_q, state_d;
   logic [ADDR_WIDTH:0]   addr_q, addr_d;
   logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
   logic                  ser_load;
   logic                  ser_last;
   logic                  advance;

   vrased_log_serializer u_ser (
      .clk         (clk),
      .reset       (reset),
      .load_i      (ser_load),
      .data_i      (rd_data),
      .out_ready_i (out_ready),
      .out_data_o  (out_data),
      .out_valid_o (out_valid),
      .out_first_o (out_first),
      .last_o      (ser_last)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      cnt_d    = cnt_q;
      re       = 1'b0;
      clr_ram  = 1'b0;
      done     = 1'b0;
      ser_load = 1'b0;
      advance  = 1'b0;
      rd_addr  = '0;
      rd_addr[ADDR_WIDTH-1:0] = addr_q[ADDR_WIDTH-1:0];
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RD;
               addr_d  = '0;
               cnt_d   = '0;
            end
         end
         ST_RD: begin
            re      = 1'b1;
            state_d = ST_CAP;
         end
         ST_CAP: begin
            if (rd_data[LOG_VALID_BIT]) begin
               ser_load = 1'b1;
               state_d  = ST_WORDS;
            end else begin
               advance = 1'b1;
            end
         end
         ST_WORDS: begin
            if (ser_last) begin
               cnt_d   = cnt_q + 1'b1;
               advance = 1'b1;
            end
         end
         ST_CLR: begin
            clr_ram = 1'b1;
            state_d = ST_FIN;
         end
         ST_FIN: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Stop at the last entry rather than wrapping back to entry 0.
      if (advance) begin
         if (addr_q == LAST_ADDR) begin
            state_d = CLEAR_AFTER ? ST_CLR : ST_FIN;
         end else begin
            addr_d  = addr_q + 1'b1;
            state_d = ST_RD;
         end
      end
   end

   assign busy      = (state_q != ST_IDLE);
   assign entry_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_vrased_log_drain.sv
// ============================================================================
// tb_vrased_log_drain : directed self-checking bench for vrased_log_drain.
// Revision            : 1.0
// ============================================================================
`default_nettype none

module tb_vrased_log_drain;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        out_ready = 1'b0;
   logic        start0 = 1'b0;
   logic        out_ready0 = 1'b0;

   logic        busy, done, re, clr_ram, out_valid, out_first;
   logic [15:0] rd_addr, out_data;
   logic [37:0] rd_data = '0;
   logic [8:0]  entry_cnt;

   logic        busy0, done0, re0, clr_ram0, out_valid0, out_first0;
   logic [15:0] rd_addr0, out_data0;
   logic [37:0] rd_data0 = '0;
   logic [8:0]  entry_cnt0;

   logic [37:0] mem [0:255];

   int checks = 0;
   int errors = 0;

   int cyc = 0, valid_n = 0, re_n = 0, clr_n = 0, done_n = 0, bad_addr = 0;
   int clr_cyc = 0, done_cyc = 0, last_re_cyc = 0, stalls = 0, stall_bad = 0;
   int done0_n = 0, clr0_n = 0, re0_n = 0;
   logic [15:0] wq [$];
   logic        fq [$];
   logic        prev_stall = 1'b0;
   logic [15:0] prev_data = '0;
   logic        prev_first = 1'b0;

   vrased_log_drain #(.ADDR_WIDTH(8), .CLEAR_AFTER(1'b1)) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
      .re(re), .rd_addr(rd_addr), .rd_data(rd_data), .clr_ram(clr_ram),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_first(out_first), .entry_cnt(entry_cnt)
   );

   vrased_log_drain #(.ADDR_WIDTH(8), .CLEAR_AFTER(1'b0)) dut0 (
      .clk(clk), .reset(reset), .start(start0), .busy(busy0), .done(done0),
      .re(re0), .rd_addr(rd_addr0), .rd_data(rd_data0), .clr_ram(clr_ram0),
      .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready0),
      .out_first(out_first0), .entry_cnt(entry_cnt0)
   );

   always #5 clk = ~clk;

   // Log RAM model: one-cycle read latency.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (re)  rd_data  <= mem[rd_addr[7:0]];
      if (re0) rd_data0 <= mem[rd_addr0[7:0]];
   end

   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         wq.push_back(out_data);
         fq.push_back(out_first);
      end
      if (out_valid) valid_n++;
      if (re) begin
         re_n++;
         last_re_cyc = cyc;
         if (rd_addr[15:8] != 8'd0) bad_addr++;
      end
      if (re0 && rd_addr0[15:8] != 8'd0) bad_addr++;
      if (re0) re0_n++;
      if (clr_ram) begin clr_n++; clr_cyc = cyc; end
      if (done) begin done_n++; done_cyc = cyc; end
      if (done0) done0_n++;
      if (clr_ram0) clr0_n++;
      if (prev_stall) begin
         stalls++;
         if (!out_valid || out_data !== prev_data || out_first !== prev_first) stall_bad++;
      end
      prev_stall = out_valid && !out_ready && !reset;
      prev_data  = out_data;
      prev_first = out_first;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = '0;
   endtask

   task automatic pulse_start(input bit which0);
      if (which0) start0 = 1'b1; else start = 1'b1;
      tick();
      start0 = 1'b0;
      start  = 1'b0;
   endtask

   task automatic wait_done(input bit which0, input int bound, input bit toggle, output bit ok);
      int d0;
      d0 = which0 ? done0_n : done_n;
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         if (toggle) out_ready = ~out_ready;
         tick();
         if ((which0 ? done0_n : done_n) != d0) begin
            ok = 1'b1;
            break;
         end
      end
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      checks++;
      if ({busy, done, re, clr_ram, out_valid, out_first} !== 6'b0) begin
         errors++; $display("FAIL reset_ctrl got %b want 000000", {busy, done, re, clr_ram, out_valid, out_first});
      end
      checks++;
      if (rd_addr !== 16'h0 || out_data !== 16'h0 || entry_cnt !== 9'd0) begin
         errors++; $display("FAIL reset_data got addr=%h data=%h cnt=%0d want 0", rd_addr, out_data, entry_cnt);
      end
      checks++;
      if ({busy0, done0, re0, clr_ram0, out_valid0, out_first0} !== 6'b0 || entry_cnt0 !== 9'd0) begin
         errors++; $display("FAIL reset_dut0 got ctrl=%b cnt=%0d want 0", {busy0, done0, re0, clr_ram0, out_valid0, out_first0}, entry_cnt0);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_empty();
      int v0, c0, d0, r0;
      bit ok;
      clear_mem();
      out_ready = 1'b1;
      v0 = valid_n; c0 = clr_n; d0 = done_n; r0 = re_n;
      pulse_start(1'b0);
      wait_done(1'b0, 1200, 1'b0, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL empty_timeout got no done want done"); end
      checks++;
      if (valid_n - v0 != 0) begin errors++; $display("FAIL empty_valid got %0d valid cycles want 0", valid_n - v0); end
      checks++;
      if (clr_n - c0 != 1 || done_n - d0 != 1) begin
         errors++; $display("FAIL empty_pulses got clr=%0d done=%0d want 1 1", clr_n - c0, done_n - d0);
      end
      checks++;
      if (done_cyc != clr_cyc + 1) begin errors++; $display("FAIL empty_done_after_clr got %0d want %0d", done_cyc, clr_cyc + 1); end
      checks++;
      if (clr_cyc != last_re_cyc + 2) begin errors++; $display("FAIL empty_clr_latency got %0d want %0d", clr_cyc, last_re_cyc + 2); end
      checks++;
      if (re_n - r0 != 256) begin errors++; $display("FAIL empty_reads got %0d want 256", re_n - r0); end
      checks++;
      if (entry_cnt !== 9'd0 || busy !== 1'b0) begin errors++; $display("FAIL empty_cnt got cnt=%0d busy=%b want 0 0", entry_cnt, busy); end
   endtask

   task automatic test_single();
      int b;
      bit ok;
      logic [15:0] exp [3];
      exp[0] = 16'hABCD; exp[1] = 16'h1234; exp[2] = 16'h0022;
      clear_mem();
      mem[5] = 38'h22_1234_ABCD;
      out_ready = 1'b1;
      b = wq.size();
      pulse_start(1'b0);
      wait_done(1'b0, 1200, 1'b0, ok);
      checks++;
      if (!ok || wq.size() - b != 3) begin errors++; $display("FAIL single_count got %0d words ok=%b want 3", wq.size() - b, ok); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (wq[b+i] !== exp[i] || fq[b+i] !== (i == 0)) begin
            errors++; $display("FAIL single_word%0d got %h first=%b want %h first=%b", i, wq[b+i], fq[b+i], exp[i], i == 0);
         end
      end
      checks++;
      if (entry_cnt !== 9'd1) begin errors++; $display("FAIL single_cnt got %0d want 1", entry_cnt); end
   endtask

   task automatic test_ends_stall();
      int b, s0, sb0, r0, ba0;
      bit ok;
      logic [15:0] exp [6];
      exp[0] = 16'hAAAA; exp[1] = 16'h5555; exp[2] = 16'h0020;
      exp[3] = 16'h0001; exp[4] = 16'hFFFF; exp[5] = 16'h003F;
      clear_mem();
      mem[0]   = 38'h20_5555_AAAA;
      mem[255] = 38'h3F_FFFF_0001;
      out_ready = 1'b0;
      b = wq.size(); s0 = stalls; sb0 = stall_bad; r0 = re_n; ba0 = bad_addr;
      pulse_start(1'b0);
      wait_done(1'b0, 1500, 1'b1, ok);
      out_ready = 1'b1;
      checks++;
      if (!ok || wq.size() - b != 6) begin errors++; $display("FAIL ends_count got %0d words ok=%b want 6", wq.size() - b, ok); end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (wq[b+i] !== exp[i] || fq[b+i] !== (i % 3 == 0)) begin
            errors++; $display("FAIL ends_word%0d got %h first=%b want %h first=%b", i, wq[b+i], fq[b+i], exp[i], i % 3 == 0);
         end
      end
      checks++;
      if (stall_bad - sb0 != 0 || stalls - s0 == 0) begin
         errors++; $display("FAIL ends_stall_stable got bad=%0d stalls=%0d want bad=0 stalls>0", stall_bad - sb0, stalls - s0);
      end
      checks++;
      if (re_n - r0 != 256 || bad_addr - ba0 != 0) begin
         errors++; $display("FAIL ends_reads got reads=%0d bad_addr=%0d want 256 0", re_n - r0, bad_addr - ba0);
      end
      checks++;
      if (entry_cnt !== 9'd2) begin errors++; $display("FAIL ends_cnt got %0d want 2", entry_cnt); end
   endtask

   task automatic test_reset_mid();
      int b, c0, d0, n;
      bit ok;
      clear_mem();
      mem[3] = 38'h25_CAFE_BEEF;
      out_ready = 1'b0;
      pulse_start(1'b0);
      n = 0;
      while (!out_valid && n < 50) begin tick(); n++; end
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'hBEEF || out_first !== 1'b1) begin
         errors++; $display("FAIL mid_w0 got v=%b data=%h first=%b want 1 beef 1", out_valid, out_data, out_first);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'hCAFE || out_first !== 1'b0) begin
         errors++; $display("FAIL mid_w1 got v=%b data=%h first=%b want 1 cafe 0", out_valid, out_data, out_first);
      end
      c0 = clr_n; d0 = done_n;
      reset = 1'b1;
      tick();
      checks++;
      if ({busy, done, re, clr_ram, out_valid, out_first} !== 6'b0 || out_data !== 16'h0 || rd_addr !== 16'h0 || entry_cnt !== 9'd0) begin
         errors++; $display("FAIL mid_reset got ctrl=%b data=%h addr=%h cnt=%0d want 0", {busy, done, re, clr_ram, out_valid, out_first}, out_data, rd_addr, entry_cnt);
      end
      reset = 1'b0;
      repeat (5) tick();
      checks++;
      if (clr_n - c0 != 0 || done_n - d0 != 0 || busy !== 1'b0) begin
         errors++; $display("FAIL mid_no_clr got clr=%0d done=%0d busy=%b want 0 0 0", clr_n - c0, done_n - d0, busy);
      end
      out_ready = 1'b1;
      b = wq.size();
      pulse_start(1'b0);
      wait_done(1'b0, 1200, 1'b0, ok);
      checks++;
      if (!ok || wq.size() - b != 3 || wq[b] !== 16'hBEEF || fq[b] !== 1'b1 || wq[b+1] !== 16'hCAFE || wq[b+2] !== 16'h0025) begin
         errors++; $display("FAIL mid_resend got n=%0d w0=%h f=%b w1=%h w2=%h want 3 beef 1 cafe 0025", wq.size() - b, wq[b], fq[b], wq[b+1], wq[b+2]);
      end
      checks++;
      if (entry_cnt !== 9'd1) begin errors++; $display("FAIL mid_cnt got %0d want 1", entry_cnt); end
   endtask

   task automatic test_back_to_back();
      int d0, c0, r0;
      bit ok;
      out_ready0 = 1'b1;
      d0 = done0_n; c0 = clr0_n; r0 = re0_n;
      pulse_start(1'b1);
      repeat (20) tick();
      pulse_start(1'b1);
      wait_done(1'b1, 1200, 1'b0, ok);
      repeat (20) tick();
      checks++;
      if (!ok || done0_n - d0 != 1) begin errors++; $display("FAIL b2b_done got %0d pulses ok=%b want 1", done0_n - d0, ok); end
      checks++;
      if (clr0_n - c0 != 0) begin errors++; $display("FAIL b2b_clr got %0d want 0", clr0_n - c0); end
      checks++;
      if (re0_n - r0 != 256 || busy0 !== 1'b0) begin
         errors++; $display("FAIL b2b_reads got %0d busy=%b want 256 0", re0_n - r0, busy0);
      end
      checks++;
      if (entry_cnt0 !== 9'd1) begin errors++; $display("FAIL b2b_cnt got %0d want 1", entry_cnt0); end
   endtask

   initial begin
      clear_mem();
      test_reset();
      test_empty();
      test_single();
      test_ends_stall();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
